// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the access FSM states, the owner port indices and the starvation counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dmem_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // 8 bits covers any STARVE_LIMIT up to 255
    localparam int STARVE_W = 8;
    typedef logic [STARVE_W-1:0] starve_cnt_t;

endpackage

// File: rtl/arb2_starve.sv
// Two-way winner select with a last-grant pointer and a starvation counter for port 1.
// Latency: winner is combinational from req; pointer and counter update on the accept strobe.
// Backpressure: none; the owner FSM only strobes accept when it can take a new access.
module arb2_starve
    import dmem_arb_pkg::*;
#(
    parameter int CPU_PRIO     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic winner
);

    localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

    logic        last_q;
    logic        last_d;
    starve_cnt_t starve_cnt_q;
    starve_cnt_t starve_cnt_d;

    always_comb begin
        winner = PORT_CPU;
        if (req1 && !req0) begin
            winner = PORT_DBG;
        end else if (req0 && req1) begin
            if (CPU_PRIO != 0) begin
                winner = (starve_cnt_q >= LIMIT) ? PORT_DBG : PORT_CPU;
            end else begin
                winner = (last_q == PORT_CPU) ? PORT_DBG : PORT_CPU;
            end
        end
    end

    // Port 1 only counts as having lost when it was actually requesting.
    always_comb begin
        last_d       = last_q;
        starve_cnt_d = starve_cnt_q;
        if (accept && (req0 || req1)) begin
            last_d = winner;
            if (winner == PORT_DBG) begin
                starve_cnt_d = '0;
            end else if (req1 && (starve_cnt_q != '1)) begin
                starve_cnt_d = starve_cnt_q + starve_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= PORT_DBG;
            starve_cnt_q <= '0;
        end else begin
            last_q       <= last_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data memory between the CPU (port 0) and a debug/loader port (port 1).
// Latency: gnt in IDLE cycle N, memory enabled in N+1, rvalid in N+2; one access per 3 cycles.
// Backpressure: requesters hold req and fields until gnt; requests are only sampled in IDLE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_BITS    = 32,
    parameter int ADDR_BITS    = 32,
    parameter int CPU_PRIO     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic [DATA_BITS-1:0] p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [DATA_BITS-1:0] p0_rdata,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic [DATA_BITS-1:0] p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [DATA_BITS-1:0] p1_rdata,
    output logic                 mem_en_n,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    dmem_state_e          state_q, state_d;
    logic                 mem_en_n_q, mem_en_n_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                 owner_q, owner_d;
    logic                 wr_q, wr_d;
    logic [DATA_BITS-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_BITS-1:0] p1_rdata_q, p1_rdata_d;

    logic                 accept;
    logic                 winner;
    logic [DATA_BITS-1:0] resp_dat;

    assign accept = (state_q == IDLE) && (p0_req || p1_req);

    arb2_starve #(
        .CPU_PRIO     (CPU_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (p0_req),
        .req1   (p1_req),
        .accept (accept),
        .winner (winner)
    );

    assign p0_gnt = accept && (winner == PORT_CPU);
    assign p1_gnt = accept && (winner == PORT_DBG);

    // The mem_* flops double as the request latch: loaded on the grant edge, held through RESP.
    always_comb begin
        state_d     = state_q;
        mem_en_n_d  = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = ISSUE;
                    mem_en_n_d  = 1'b0;
                    owner_d     = winner;
                    if (winner == PORT_DBG) begin
                        mem_we_d    = p1_we;
                        wr_d        = p1_we;
                        mem_addr_d  = p1_addr;
                        mem_wdata_d = p1_wdata;
                    end else begin
                        mem_we_d    = p0_we;
                        wr_d        = p0_we;
                        mem_addr_d  = p0_addr;
                        mem_wdata_d = p0_wdata;
                    end
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign p0_rvalid = (state_q == RESP) && (owner_q == PORT_CPU);
    assign p1_rvalid = (state_q == RESP) && (owner_q == PORT_DBG);

    // Writes echo the latched write data rather than whatever the memory drives out.
    assign resp_dat = wr_q ? mem_wdata_q : mem_rdata;

    always_comb begin
        p0_rdata_d = p0_rvalid ? resp_dat : p0_rdata_q;
        p1_rdata_d = p1_rvalid ? resp_dat : p1_rdata_q;
    end

    assign p0_rdata  = p0_rdata_d;
    assign p1_rdata  = p1_rdata_d;
    assign mem_en_n  = mem_en_n_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_en_n_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= PORT_CPU;
            wr_q        <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_n_q  <= mem_en_n_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a priority/starvation instance with a memory model, plus a round-robin instance.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en_n, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        r_p0_req, r_p1_req;
    logic        r_p0_gnt, r_p0_rvalid, r_p1_gnt, r_p1_rvalid;
    logic [31:0] r_p0_rdata, r_p1_rdata;
    logic        r_mem_en_n, r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [31:0] r_mem_rdata;

    int vecs = 0;
    int errs = 0;

    // Unwritten words read back as CAFEF0xx so a lost write is visible.
    logic [31:0]  mem [0:255];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (!mem_en_n) begin
            if (mem_we) begin
                mem[mem_addr[7:0]]     <= mem_wdata;
                written[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : {24'hCAFEF0, mem_addr[7:0]};
            end
        end
    end

    dmem_arbiter #(.DATA_BITS(32), .ADDR_BITS(32), .CPU_PRIO(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en_n(mem_en_n), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign r_mem_rdata = 32'h0;

    dmem_arbiter #(.DATA_BITS(32), .ADDR_BITS(32), .CPU_PRIO(0), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(r_p0_req), .p0_we(1'b0), .p0_addr(32'h4), .p0_wdata(32'h0),
        .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rvalid), .p0_rdata(r_p0_rdata),
        .p1_req(r_p1_req), .p1_we(1'b0), .p1_addr(32'h8), .p1_wdata(32'h0),
        .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rvalid), .p1_rdata(r_p1_rdata),
        .mem_en_n(r_mem_en_n), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_rdata(r_mem_rdata)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        r_p0_req = 0; r_p1_req = 0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({mem_en_n, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
            errs++; $display("FAIL reset_mem: got en_n=%b we=%b addr=%h wdata=%h want 1 0 0 0", mem_en_n, mem_we, mem_addr, mem_wdata);
        end
        vecs++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0000 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errs++; $display("FAIL reset_ports: got gnt=%b%b rvalid=%b%b rdata=%h/%h want all zero", p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if ({mem_en_n, r_mem_en_n, p0_gnt, p1_gnt} !== 4'b1100) begin
            errs++; $display("FAIL reset_idle: got en_n=%b rr_en_n=%b gnt=%b%b want 1 1 00", mem_en_n, r_mem_en_n, p0_gnt, p1_gnt);
        end
    endtask

    task automatic test_p0_write();
        p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
        #1;
        vecs++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errs++; $display("FAIL p0w_gnt: got p0_gnt=%b p1_gnt=%b want 1 0", p0_gnt, p1_gnt);
        end
        @(negedge clk);
        vecs++;
        if ({mem_en_n, mem_we, mem_addr, mem_wdata, p0_gnt} !== {1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0}) begin
            errs++; $display("FAIL p0w_issue: got en_n=%b we=%b addr=%h wdata=%h gnt=%b want 0 1 10 deadbeef 0", mem_en_n, mem_we, mem_addr, mem_wdata, p0_gnt);
        end
        p0_req = 0;
        @(negedge clk);
        vecs++;
        if ({p0_rvalid, p1_rvalid, mem_en_n, mem_we} !== 4'b1010 || p0_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL p0w_resp: got rvalid=%b%b en_n=%b we=%b rdata=%h want 10 1 0 deadbeef", p0_rvalid, p1_rvalid, mem_en_n, mem_we, p0_rdata);
        end
        @(negedge clk);
        vecs++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL p0w_after: got rvalid=%b rdata=%h want 0 deadbeef", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_p1_read();
        p1_req = 1; p1_we = 0; p1_addr = 32'h10;
        #1;
        vecs++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin
            errs++; $display("FAIL p1r_gnt: got p0_gnt=%b p1_gnt=%b want 0 1", p0_gnt, p1_gnt);
        end
        @(negedge clk);
        p1_req = 0;
        vecs++;
        if ({mem_en_n, mem_we, mem_addr} !== {1'b0, 1'b0, 32'h10}) begin
            errs++; $display("FAIL p1r_issue: got en_n=%b we=%b addr=%h want 0 0 10", mem_en_n, mem_we, mem_addr);
        end
        @(negedge clk);
        vecs++;
        if ({p0_rvalid, p1_rvalid} !== 2'b01 || p1_rdata !== 32'hDEADBEEF || p0_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL p1r_resp: got rvalid=%b%b p1_rdata=%h p0_rdata=%h want 01 deadbeef deadbeef", p0_rvalid, p1_rvalid, p1_rdata, p0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_starve();
        int k = 0;
        int last_cyc = 0;
        int n0 = 0;
        int n1 = 0;
        int exp_port;
        p0_req = 1; p0_we = 0; p0_addr = 32'h1;
        p1_req = 1; p1_we = 0; p1_addr = 32'h2;
        for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
            #1;
            if (p0_rvalid) n0++;
            if (p1_rvalid) n1++;
            if (p0_gnt || p1_gnt) begin
                exp_port = (k == 4 || k == 9) ? 1 : 0;
                vecs++;
                if ((p0_gnt && p1_gnt) || (p1_gnt !== exp_port[0])) begin
                    errs++; $display("FAIL starve_order[%0d]: got gnt=%b%b want port %0d", k, p0_gnt, p1_gnt, exp_port);
                end
                if (k > 0) begin
                    vecs++;
                    if (cyc - last_cyc != 3) begin
                        errs++; $display("FAIL starve_spacing[%0d]: got %0d cycles want 3", k, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                k++;
            end
            @(negedge clk);
        end
        p0_req = 0; p1_req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (p0_rvalid) n0++;
            if (p1_rvalid) n1++;
            @(negedge clk);
        end
        vecs++;
        if (k != 10 || n0 != 8 || n1 != 2) begin
            errs++; $display("FAIL starve_counts: got grants=%0d rvalid0=%0d rvalid1=%0d want 10 8 2", k, n0, n1);
        end
    endtask

    task automatic test_round_robin();
        int k = 0;
        int last_cyc = 0;
        r_p0_req = 1; r_p1_req = 1;
        for (int cyc = 0; cyc < 30 && k < 6; cyc++) begin
            #1;
            if (r_p0_gnt || r_p1_gnt) begin
                vecs++;
                if ((r_p0_gnt && r_p1_gnt) || (r_p1_gnt !== k[0])) begin
                    errs++; $display("FAIL rr_order[%0d]: got gnt=%b%b want port %0d", k, r_p0_gnt, r_p1_gnt, k % 2);
                end
                if (k > 0) begin
                    vecs++;
                    if (cyc - last_cyc != 3) begin
                        errs++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", k, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                k++;
            end
            @(negedge clk);
        end
        r_p0_req = 0; r_p1_req = 0;
        repeat (3) @(negedge clk);
        vecs++;
        if (k != 6) begin
            errs++; $display("FAIL rr_count: got %0d grants want 6", k);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'h12345678;
        #1;
        vecs++;
        if (p0_gnt !== 1'b1) begin
            errs++; $display("FAIL rst_mid_gnt: got %b want 1", p0_gnt);
        end
        @(negedge clk);
        p0_req = 0;
        vecs++;
        if ({mem_en_n, mem_we} !== 2'b01) begin
            errs++; $display("FAIL rst_mid_issue: got en_n=%b we=%b want 0 1", mem_en_n, mem_we);
        end
        #1 rst_n = 1'b0;
        #1;
        vecs++;
        if ({mem_en_n, mem_we} !== 2'b10) begin
            errs++; $display("FAIL rst_mid_async: got en_n=%b we=%b want 1 0", mem_en_n, mem_we);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (p0_rvalid || p1_rvalid) nv++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (p0_rvalid || p1_rvalid) nv++;
            @(negedge clk);
        end
        vecs++;
        if (nv != 0 || p0_rdata !== 32'h0) begin
            errs++; $display("FAIL rst_mid_drop: got rvalid pulses=%0d p0_rdata=%h want 0 0", nv, p0_rdata);
        end
        p1_req = 1; p1_we = 0; p1_addr = 32'h20;
        #1;
        vecs++;
        if (p1_gnt !== 1'b1) begin
            errs++; $display("FAIL rst_mid_rd_gnt: got %b want 1", p1_gnt);
        end
        @(negedge clk);
        p1_req = 0;
        @(negedge clk);
        vecs++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hCAFEF020) begin
            errs++; $display("FAIL rst_mid_old: got rvalid=%b rdata=%h want 1 cafef020", p1_rvalid, p1_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_held_request();
        p1_req = 1; p1_we = 1; p1_addr = 32'h30; p1_wdata = 32'h11112222;
        #1;
        vecs++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin
            errs++; $display("FAIL held_p1_gnt: got gnt=%b%b want 01", p0_gnt, p1_gnt);
        end
        @(negedge clk);
        p1_req = 0;
        p0_req = 1; p0_we = 0; p0_addr = 32'h30;
        #1;
        vecs++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            errs++; $display("FAIL held_issue_gnt: got gnt=%b%b want 00", p0_gnt, p1_gnt);
        end
        @(negedge clk);
        vecs++;
        if ({p0_gnt, p0_rvalid, p1_rvalid} !== 3'b001 || p1_rdata !== 32'h11112222) begin
            errs++; $display("FAIL held_resp: got p0_gnt=%b rvalid=%b%b p1_rdata=%h want 0 01 11112222", p0_gnt, p0_rvalid, p1_rvalid, p1_rdata);
        end
        @(negedge clk);
        vecs++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errs++; $display("FAIL held_idle_gnt: got gnt=%b%b want 10", p0_gnt, p1_gnt);
        end
        @(negedge clk);
        p0_req = 0;
        vecs++;
        if ({p0_gnt, mem_en_n, mem_we, mem_addr} !== {1'b0, 1'b0, 1'b0, 32'h30}) begin
            errs++; $display("FAIL held_issue2: got gnt=%b en_n=%b we=%b addr=%h want 0 0 0 30", p0_gnt, mem_en_n, mem_we, mem_addr);
        end
        @(negedge clk);
        vecs++;
        if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'h11112222) begin
            errs++; $display("FAIL held_p0_resp: got rvalid=%b%b rdata=%h want 10 11112222", p0_rvalid, p1_rvalid, p0_rdata);
        end
        @(negedge clk);
        vecs++;
        if ({p0_gnt, p0_rvalid, p1_gnt, p1_rvalid} !== 4'b0000) begin
            errs++; $display("FAIL held_quiet: got gnt/rvalid=%b%b%b%b want 0000", p0_gnt, p0_rvalid, p1_gnt, p1_rvalid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_p0_write();
        test_p1_read();
        test_starve();
        test_round_robin();
        test_reset_mid();
        test_held_request();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
